// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: drives mux selects, write enables and the memory handshake.
// Optional macro MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN: unrecognised opcodes park in HALT with illegal=1.
module multicycle_controller #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic                     alu_zero,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic                     adr_src,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     reg_write,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic [1:0]               result_src,
    output logic [1:0]               imm_sel,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic                     illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALRADR,
        S_JALR,
        S_HALT
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_retire;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic                     w_unused;

    // Only BEQ/BNE are supported, so funct3[0] alone selects the branch sense.
    assign w_unused = ^funct3[2:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign instret = r_instret;

`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    assign illegal = (r_state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        result_src = 2'd0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute branch/jal target into alu_out while the opcode is decoded.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALRADR;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
                    default:           w_next = S_HALT;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                w_next    = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd2;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_op    = 2'd2;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd1;
                pc_write  = alu_zero ^ funct3[0];
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL, S_JALR: begin
                // PC takes the target held in alu_out while the ALU forms old_pc+4 as the link value.
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                w_next    = S_ALUWB;
            end
            S_JALRADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                w_next    = S_JALR;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_comb begin
        imm_sel = 2'd0;
        case (opcode)
            OP_STORE:  imm_sel = 2'd1;
            OP_BRANCH: imm_sel = 2'd2;
            OP_JAL:    imm_sel = 2'd3;
            default:   imm_sel = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes hand-computed per-cycle controls, a negedge monitor compares.
// Follows MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_controller;

    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src, imm_sel;
    logic [IW-1:0] instret;

    multicycle_controller #(.INSTRET_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .imm_sel(imm_sel), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;

    logic [13+2+1+IW:0] q_exp[$];
    string              q_nm[$];
    logic [IW-1:0]      exp_cnt = '0;
    int                 tests = 0;
    int                 failures = 0;

    logic [13:0] C_FW, C_FR, C_DEC, C_MA, C_MR, C_MWB, C_MW, C_ER, C_EI, C_AWB, C_BRT, C_BRN, C_J, C_JA, C_Z;

    // Bit order: mem_req mem_write adr_src ir_write pc_write reg_write alu_src_a alu_src_b alu_op result_src
    function automatic logic [13:0] mk(input bit mr, input bit mw, input bit ad, input bit ir,
                                       input bit pc, input bit rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op, input logic [1:0] rs);
        return {mr, mw, ad, ir, pc, rw, a, b, op, rs};
    endfunction

    function automatic logic [1:0] imm_for(input logic [6:0] op);
        case (op)
            SW:      return 2'd1;
            BR:      return 2'd2;
            JAL:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input bit z, input bit rdy,
                        input logic [13:0] ctl, input bit ill, input bit ret, input string nm);
        opcode    = op;
        funct3    = f3;
        alu_zero  = z;
        mem_ready = rdy;
        q_exp.push_back({ctl, imm_for(op), ill, exp_cnt});
        q_nm.push_back(nm);
        if (ret) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = '0;
    endtask

    always @(negedge clk) begin
        logic [13+2+1+IW:0] e, act;
        string              n;
        if (q_exp.size() != 0) begin
            e   = q_exp.pop_front();
            n   = q_nm.pop_front();
            act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, alu_op, result_src, imm_sel, illegal, instret};
            tests++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h (t=%0t)", n, act, e, $time);
            end
        end
    end

    initial begin
        C_FW  = mk(1,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd2);
        C_FR  = mk(1,0,0,1,1,0, 2'd0, 2'd2, 2'd0, 2'd2);
        C_DEC = mk(0,0,0,0,0,0, 2'd1, 2'd1, 2'd0, 2'd0);
        C_MA  = mk(0,0,0,0,0,0, 2'd2, 2'd1, 2'd0, 2'd0);
        C_MR  = mk(1,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0);
        C_MWB = mk(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 2'd1);
        C_MW  = mk(1,1,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0);
        C_ER  = mk(0,0,0,0,0,0, 2'd2, 2'd0, 2'd2, 2'd0);
        C_EI  = mk(0,0,0,0,0,0, 2'd2, 2'd1, 2'd2, 2'd0);
        C_AWB = mk(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 2'd0);
        C_BRT = mk(0,0,0,0,1,0, 2'd2, 2'd0, 2'd1, 2'd0);
        C_BRN = mk(0,0,0,0,0,0, 2'd2, 2'd0, 2'd1, 2'd0);
        C_J   = mk(0,0,0,0,1,0, 2'd1, 2'd2, 2'd0, 2'd0);
        C_JA  = mk(0,0,0,0,0,0, 2'd2, 2'd1, 2'd0, 2'd0);
        C_Z   = mk(0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0);

        @(posedge clk); #1;
        do_reset();

        // ADDI, 4 cycles, reg_write only in ALUWB
        step(ADDI, 3'd0, 0, 1, C_FR,  0, 0, "addi_fetch");
        step(ADDI, 3'd0, 0, 1, C_DEC, 0, 0, "addi_decode");
        step(ADDI, 3'd0, 0, 1, C_EI,  0, 0, "addi_execi");
        step(ADDI, 3'd0, 0, 1, C_AWB, 0, 1, "addi_aluwb");

        // reset in the middle of a stalled MEMREAD
        step(LW, 3'd2, 0, 1, C_FR,  0, 0, "rst_lw_fetch");
        step(LW, 3'd2, 0, 1, C_DEC, 0, 0, "rst_lw_decode");
        step(LW, 3'd2, 0, 1, C_MA,  0, 0, "rst_lw_memadr");
        step(LW, 3'd2, 0, 0, C_MR,  0, 0, "rst_lw_memread_wait");
        mem_ready = 1'b0;
        do_reset();
        step(LW, 3'd2, 0, 0, C_FW,  0, 0, "post_reset_fetch");

        // LW with 3 wait cycles in FETCH and MEMREAD: 11 cycles
        for (int i = 0; i < 3; i++) step(LW, 3'd2, 0, 0, C_FW, 0, 0, "lw_fetch_wait");
        step(LW, 3'd2, 0, 1, C_FR,  0, 0, "lw_fetch");
        step(LW, 3'd2, 0, 1, C_DEC, 0, 0, "lw_decode");
        step(LW, 3'd2, 0, 1, C_MA,  0, 0, "lw_memadr");
        for (int i = 0; i < 3; i++) step(LW, 3'd2, 0, 0, C_MR, 0, 0, "lw_memread_wait");
        step(LW, 3'd2, 0, 1, C_MR,  0, 0, "lw_memread");
        step(LW, 3'd2, 0, 1, C_MWB, 0, 1, "lw_memwb");

        // BEQ taken, BNE not taken, both with alu_zero=1
        step(BR, 3'd0, 1, 1, C_FR,  0, 0, "beq_fetch");
        step(BR, 3'd0, 1, 1, C_DEC, 0, 0, "beq_decode");
        step(BR, 3'd0, 1, 1, C_BRT, 0, 1, "beq_branch");
        step(BR, 3'd1, 1, 1, C_FR,  0, 0, "bne_fetch");
        step(BR, 3'd1, 1, 1, C_DEC, 0, 0, "bne_decode");
        step(BR, 3'd1, 1, 1, C_BRN, 0, 1, "bne_branch");

        // JALR, 5 cycles
        step(JALR, 3'd0, 0, 1, C_FR,  0, 0, "jalr_fetch");
        step(JALR, 3'd0, 0, 1, C_DEC, 0, 0, "jalr_decode");
        step(JALR, 3'd0, 0, 1, C_JA,  0, 0, "jalr_adr");
        step(JALR, 3'd0, 0, 1, C_J,   0, 0, "jalr_jalr");
        step(JALR, 3'd0, 0, 1, C_AWB, 0, 1, "jalr_aluwb");

        // SW, 4 cycles
        step(SW, 3'd2, 0, 1, C_FR,  0, 0, "sw_fetch");
        step(SW, 3'd2, 0, 1, C_DEC, 0, 0, "sw_decode");
        step(SW, 3'd2, 0, 1, C_MA,  0, 0, "sw_memadr");
        step(SW, 3'd2, 0, 1, C_MW,  0, 1, "sw_memwrite");

        // ADD (R-type)
        step(ADD, 3'd0, 0, 1, C_FR,  0, 0, "add_fetch");
        step(ADD, 3'd0, 0, 1, C_DEC, 0, 0, "add_decode");
        step(ADD, 3'd0, 0, 1, C_ER,  0, 0, "add_execr");
        step(ADD, 3'd0, 0, 1, C_AWB, 0, 1, "add_aluwb");

        // JAL
        step(JAL, 3'd0, 0, 1, C_FR,  0, 0, "jal_fetch");
        step(JAL, 3'd0, 0, 1, C_DEC, 0, 0, "jal_decode");
        step(JAL, 3'd0, 0, 1, C_J,   0, 0, "jal_jal");
        step(JAL, 3'd0, 0, 1, C_AWB, 0, 1, "jal_aluwb");

        // eighth retirement since reset wraps the 3-bit counter to 0
        step(ADDI, 3'd0, 0, 1, C_FR,  0, 0, "wrap_fetch");
        step(ADDI, 3'd0, 0, 1, C_DEC, 0, 0, "wrap_decode");
        step(ADDI, 3'd0, 0, 1, C_EI,  0, 0, "wrap_execi");
        step(ADDI, 3'd0, 0, 1, C_AWB, 0, 1, "wrap_aluwb");
        step(ADDI, 3'd0, 0, 0, C_FW,  0, 0, "wrap_check");

        // unrecognised opcode
        step(LUI, 3'd0, 0, 1, C_FR,  0, 0, "lui_fetch");
        step(LUI, 3'd0, 0, 1, C_DEC, 0, 0, "lui_decode");
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
        step(LUI, 3'd0, 0, 1, C_Z,   1, 0, "lui_halt");
        step(LUI, 3'd0, 0, 1, C_Z,   1, 0, "lui_halt_hold");
        do_reset();
        step(LUI, 3'd0, 0, 0, C_FW,  0, 0, "halt_reset_fetch");
`else
        step(LUI, 3'd0, 0, 0, C_FW,  0, 0, "lui_noop_fetch");
        step(LUI, 3'd0, 0, 1, C_FR,  0, 0, "lui_noop_fetch2");
`endif

        @(posedge clk); #1;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
